otter_div_unit: RTL and testbench

//   Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU) beside the OTTER ALU.
//   The ALU is single-cycle combinational; this block is its iterative counterpart.
//   It accepts operands with a start pulse, runs a restoring shift-subtract loop,

---
 rtl/otter_div_unit.sv | 144 ++++++++++++++
 tb/tb_otter_div_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/otter_div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) for the OTTER core.
// Restoring shift-subtract, one quotient bit per cycle, with a one-cycle fast path for special cases.
module otter_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;

  logic             w_signed;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_fast_result;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_rem_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_final;

  // Operand conditioning, evaluated only while IDLE on the live inputs.
  assign w_signed   = ~op[0];
  assign w_abs_a    = (w_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_abs_b    = (w_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = w_signed && (dividend == MIN_NEG) && (divisor == '1);

  always_comb begin
    w_fast_result = '0;
    if (w_div_zero)
      w_fast_result = op[1] ? dividend : '1;
    else if (w_ovf)
      w_fast_result = op[1] ? '0 : MIN_NEG;
  end

  // The dividend register doubles as the quotient: quotient bits enter at the LSB
  // as dividend bits leave at the MSB. The borrow of the W+1-bit subtract is the compare.
  assign w_rem_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_rem_sub   = w_rem_shift - {1'b0, r_dvs};
  assign w_ge        = ~w_rem_sub[WIDTH];
  assign w_rem_next  = w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
  assign w_q_next    = {r_dvd[WIDTH-2:0], w_ge};

  always_comb begin
    w_final = '0;
    if (r_is_rem)
      w_final = r_neg_r ? -w_rem_next : w_rem_next;
    else
      w_final = r_neg_q ? -w_q_next : w_q_next;
  end

  always_ff @(posedge CLK) begin
    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (RST) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_is_rem <= op[1];
            r_neg_q  <= w_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r  <= w_signed && dividend[WIDTH-1];
            r_dvd    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            if (w_div_zero || w_ovf) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_result <= w_fast_result;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_next;
          r_dvd <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_result <= w_final;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_otter_div_unit.sv
// Self-checking bench for otter_div_unit: directed vector table, hand-written
// multi-cycle corner sequences, and random operations against an arithmetic model.
module tb_otter_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;

  otter_div_unit #(.WIDTH(32)) dut (
    .CLK      (clk),
    .RST      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: RV32M semantics straight from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic is_signed;
    logic is_rem;
    is_signed = ~o[0];
    is_rem    = o[1];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_signed) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
      return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return is_rem ? a % b : a / b;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one operation and wait for done. inj_cyc >= 0 pulses a competing start
  // (DIVU 9/3) during that cycle, which must be dropped.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string name,
                       input int inj_cyc);
    int cyc;
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; op = 2'($urandom);
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == inj_cyc) begin
        start = 1'b1; op = OP_DIVU; dividend = 32'd9; divisor = 32'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy_in_done"}, 32'(busy), 32'd1);
    check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({name, "_result"}, result, exp);
    @(posedge clk); #1;
    check({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    check({name, "_result_held"}, result, exp);
  endtask

  vec_t vecs[12];

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33, "divu_100_7"};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33, "remu_100_7"};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, "div_m7_2"};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, "rem_m7_2"};
    vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33, "rem_7_m2"};
    vecs[5]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "divu_5_0"};
    vecs[6]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1,  "remu_5_0"};
    vecs[7]  = '{OP_DIV,  32'd0,          32'd0,          32'hFFFF_FFFF,  1,  "div_0_0"};
    vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "div_ovf"};
    vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "rem_ovf"};
    vecs[10] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, "divu_big"};
    vecs[11] = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33, "div_m100_7"};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, -1);

    // Competing start during CALC is dropped; back-to-back start right after done is taken.
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "drop_start", 10);
    do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "after_drop", -1);

    // Mid-operation reset aborts with no done and clears result.
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "pre_reset", -1);
    @(negedge clk);
    op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    begin
      int n_done = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (done) n_done++;
      end
      check("abort_no_done", 32'(n_done), 32'd0);
    end
    do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "post_reset", -1);

    // Random operations, biased toward the special cases.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      do_op(o, a, b, model(o, a, b), model_lat(o, a, b), $sformatf("rand%0d", i), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
